// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the SIPO deserializer.
// PARITY_CHECK_EN lengthens each frame by one even-parity bit.
package sipo_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int PARITY_BITS = 1;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Serial bits per frame, including the parity bit when enabled.
  function automatic int frame_len(input int width);
`ifdef PARITY_CHECK_EN
    return width + PARITY_BITS;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input / parallel output bundle of the SIPO deserializer.
// Handshake: a word transfers on a clock edge where out_valid && out_ready; out_valid never depends on out_ready.
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int CNT_W = cnt_w(WIDTH);

  logic             din;
  logic             din_valid;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             parity_err;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output din, din_valid, out_ready,
    input  data_out, out_valid, overrun, parity_err, bit_cnt
  );

  modport slave (
    input  din, din_valid, out_ready,
    output data_out, out_valid, overrun, parity_err, bit_cnt
  );

endinterface

// File: rtl/sipo_bit_counter.sv
// Counts din_valid strobes within a frame and flags the strobe that ends it.
module sipo_bit_counter #(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  // clr outranks a completing bit, so no frame can finish on a clearing edge.
  assign frame_done = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver, MSB first, with a one-entry output slot and sticky overrun.
// Define PARITY_CHECK_EN to receive an even-parity bit after each word and report it on parity_err.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  sipo_deserializer_if.slave bus
);

  localparam int CNT_W     = cnt_w(WIDTH);
  localparam int FRAME_LEN = frame_len(WIDTH);
  // Bits held before the final strobe: WIDTH-1 data bits, or all WIDTH when parity follows.
  localparam int SREG_W    = FRAME_LEN - 1;

  logic [SREG_W-1:0] shreg;
  logic [WIDTH-1:0]  data_q;
  logic [WIDTH-1:0]  word;
  logic              out_valid_q;
  logic              overrun_q;
  logic              parity_q;
  logic              parity_new;
  logic              shift_en;
  logic              frame_done;
  logic [CNT_W-1:0]  cnt;

  sipo_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_bit_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .en         (bus.din_valid),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

`ifdef PARITY_CHECK_EN
  // The parity bit is checked, never shifted in.
  assign word       = shreg;
  assign shift_en   = bus.din_valid && !frame_done;
  assign parity_new = ^{shreg, bus.din};
`else
  assign word       = {shreg, bus.din};
  assign shift_en   = bus.din_valid;
  assign parity_new = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      parity_q    <= 1'b0;
    end else if (clr) begin
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      if (shift_en) shreg <= SREG_W'({shreg, bus.din});
      if (frame_done) begin
        if (!out_valid_q || bus.out_ready) begin
          data_q      <= word;
          out_valid_q <= 1'b1;
          parity_q    <= parity_new;
        end else begin
          // Slot still full and not draining: drop the new word.
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.parity_err = parity_q;
  assign bus.bit_cnt    = cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer with a word scoreboard on the output handshake.
module tb_sipo_deserializer;
  import sipo_pkg::*;

  localparam int W = 4;
`ifdef PARITY_CHECK_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(W)) bus();

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FL-1:0] frame(input logic [W-1:0] w);
`ifdef PARITY_CHECK_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic send_range(input logic [FL-1:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus.din       = f[i];
      bus.din_valid = 1'b1;
      tick();
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit push);
    if (push) exp_q.push_back(w);
    send_range(frame(w), FL - 1, 0);
  endtask

  // Scoreboard: every accepted word must be the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_unexpected: observed %0h expected no word", bus.data_out);
      end else begin
        chk("sb_word", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [FL-1:0] f;
    logic [W-1:0]  rw;

    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(bus.data_out), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    chk("rst_parity", 32'(bus.parity_err), 0);
    chk("rst_cnt", 32'(bus.bit_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Basic frame 0111, slot held until consumed
    exp_q.push_back(4'b0111);
    f = frame(4'b0111);
    send_range(f, FL - 1, FL - 2);
    chk("mid_cnt", 32'(bus.bit_cnt), 2);
    send_range(f, FL - 3, 0);
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_data", 32'(bus.data_out), 32'h7);
    chk("t1_cnt", 32'(bus.bit_cnt), 0);
    chk("t1_parity", 32'(bus.parity_err), 0);
    bus.out_ready = 1'b1;
    tick();
    chk("t1_consumed", 32'(bus.out_valid), 0);
    chk("t1_hold", 32'(bus.data_out), 32'h7);

    // Gap between bits 2 and 3
    exp_q.push_back(4'b0101);
    f = frame(4'b0101);
    send_range(f, FL - 1, FL - 2);
    tick();
    chk("gap_cnt", 32'(bus.bit_cnt), 2);
    send_range(f, FL - 3, 0);
    chk("t2_valid", 32'(bus.out_valid), 1);
    chk("t2_data", 32'(bus.data_out), 32'h5);
    tick();
    chk("t2_one_cycle", 32'(bus.out_valid), 0);

    // Overrun
    bus.out_ready = 1'b0;
    send_word(4'b0111, 1'b1);
    send_word(4'b1010, 1'b0);
    chk("ovr_data", 32'(bus.data_out), 32'h7);
    chk("ovr_flag", 32'(bus.overrun), 1);
    chk("ovr_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    tick();
    chk("ovr_drain", 32'(bus.out_valid), 0);
    chk("ovr_sticky", 32'(bus.overrun), 1);
    bus.out_ready = 1'b0;
    tick();
    chk("ovr_sticky2", 32'(bus.overrun), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_overrun", 32'(bus.overrun), 0);
    chk("clr_cnt", 32'(bus.bit_cnt), 0);

    // Simultaneous consume and complete
    send_word(4'b1100, 1'b1);
    exp_q.push_back(4'b0011);
    f = frame(4'b0011);
    send_range(f, FL - 1, 1);
    bus.out_ready = 1'b1;
    send_range(f, 0, 0);
    chk("b2b_valid", 32'(bus.out_valid), 1);
    chk("b2b_data", 32'(bus.data_out), 32'h3);
    chk("b2b_overrun", 32'(bus.overrun), 0);
    tick();
    chk("b2b_drain", 32'(bus.out_valid), 0);

    // Async reset mid-frame
    send_range(frame(4'b1101), FL - 1, FL - 2);
    rst_n = 1'b0;
    #2;
    chk("arst_cnt", 32'(bus.bit_cnt), 0);
    chk("arst_data", 32'(bus.data_out), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_word(4'b1001, 1'b1);
    chk("arst_word", 32'(bus.data_out), 32'h9);
    chk("arst_valid", 32'(bus.out_valid), 1);
    tick();

    // clr after 3 bits, din ignored on the clearing edge
    send_range(frame(4'b1011), FL - 1, FL - 3);
    clr           = 1'b1;
    bus.din       = 1'b1;
    bus.din_valid = 1'b1;
    tick();
    clr           = 1'b0;
    bus.din_valid = 1'b0;
    chk("clr_mid_cnt", 32'(bus.bit_cnt), 0);
    chk("clr_keep_data", 32'(bus.data_out), 32'h9);
    send_word(4'b0110, 1'b1);
    chk("clr_word", 32'(bus.data_out), 32'h6);
    chk("clr_word_valid", 32'(bus.out_valid), 1);
    tick();

`ifdef PARITY_CHECK_EN
    bus.out_ready = 1'b0;
    exp_q.push_back(4'b0111);
    send_range(5'b0111_1, 4, 0);
    chk("par_ok", 32'(bus.parity_err), 0);
    bus.out_ready = 1'b1;
    tick();
    exp_q.push_back(4'b0101);
    send_range(5'b0101_1, 4, 0);
    chk("par_bad_data", 32'(bus.data_out), 32'h5);
    chk("par_bad", 32'(bus.parity_err), 1);
    tick();
`endif

    // Random words streamed with a ready consumer
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rw = W'($urandom_range(0, (1 << W) - 1));
      send_word(rw, 1'b1);
      chk("rnd_data", 32'(bus.data_out), 32'(rw));
    end
    repeat (3) tick();
    chk("sb_drained", 32'(exp_q.size()), 0);
    chk("end_overrun", 32'(bus.overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
